mem_access_stage: RTL

Memory-access stage of the RV32I pipeline, directly downstream of the execute-stage ALU. It takes the ALU result (the effective address, or the plain result for non-memory ops) with store data and control. It runs a request/acknowledge transaction to data memory with byte-lane alignment, sign- or zero-extends load data, and presents one writeback beat per accepted instruction. Misaligned or illegal accesses never reach memory and are flagged.

---
 rtl/mem_access_stage.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_stage
//  Description : RV32I memory-access stage. Runs one request/acknowledge
//                transaction per load/store with byte-lane alignment,
//                extends load data, flags misaligned/illegal accesses and
//                emits one writeback beat per accepted instruction.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access_stage (
   input  logic        clk,
   input  logic        reset,
   input  logic        ex_valid,
   output logic        ex_ready,
   input  logic [31:0] ex_alu_out,
   input  logic [31:0] ex_store_data,
   input  logic [4:0]  ex_rd,
   input  logic        ex_mem_read,
   input  logic        ex_mem_write,
   input  logic        ex_reg_write,
   input  logic [2:0]  ex_funct3,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_be,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        wb_valid,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic        wb_reg_write,
   output logic        misalign
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t      state;
   state_t      state_next;

   logic        accept;
   logic        mem_op;
   logic        fault;
   logic [1:0]  lane_in;
   logic [3:0]  be_in;
   logic [31:0] wdata_in;

   // Captured at accept, needed to extract load data at ack time
   logic [2:0]  funct3_q;
   logic [1:0]  lane_q;
   logic        load_q;
   logic        fault_q;

   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] load_data;

   // Ready is withheld during reset so nothing is accepted at a reset edge
   assign ex_ready = (state == IDLE) && !reset;
   assign accept   = ex_valid && ex_ready;
   assign wb_valid = (state == RESP);
   assign misalign = (state == RESP) && fault_q;

   // Decode fault conditions and byte-lane enables/data for the incoming op
   always_comb begin
      lane_in  = ex_alu_out[1:0];
      mem_op   = ex_mem_read | ex_mem_write;
      fault    = 1'b0;
      be_in    = 4'b0000;
      wdata_in = 32'h0;
      if (mem_op) begin
         if (ex_mem_read && ex_mem_write)
            fault = 1'b1;
         if (ex_funct3 == 3'b011 || ex_funct3[2:1] == 2'b11)
            fault = 1'b1;
         if (ex_mem_write && ex_funct3[2])
            fault = 1'b1;
         if (ex_funct3[1:0] == 2'b01 && lane_in[0])
            fault = 1'b1;
         if (ex_funct3 == 3'b010 && lane_in != 2'b00)
            fault = 1'b1;
      end
      case (ex_funct3[1:0])
         2'b00: begin
            be_in    = 4'b0001 << lane_in;
            wdata_in = {4{ex_store_data[7:0]}};
         end
         2'b01: begin
            be_in    = lane_in[1] ? 4'b1100 : 4'b0011;
            wdata_in = {2{ex_store_data[15:0]}};
         end
         default: begin
            be_in    = 4'b1111;
            wdata_in = ex_store_data;
         end
      endcase
   end

   // Select and extend the addressed lane of the returned word
   always_comb begin
      ld_byte   = dmem_rdata[8*lane_q +: 8];
      ld_half   = lane_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
      load_data = dmem_rdata;
      case (funct3_q)
         3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
         3'b100:  load_data = {24'h0, ld_byte};
         3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
         3'b101:  load_data = {16'h0, ld_half};
         default: load_data = dmem_rdata;
      endcase
   end

   // Next-state decode; faults and non-memory ops skip straight to RESP
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = (mem_op && !fault) ? WAIT : RESP;
         WAIT:    if (dmem_ack) state_next = RESP;
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_next;
   end

   // Capture the instruction, drive the memory request and build the beat
   always_ff @(posedge clk) begin
      if (reset) begin
         dmem_req     <= 1'b0;
         dmem_we      <= 1'b0;
         dmem_addr    <= 32'h0;
         dmem_wdata   <= 32'h0;
         dmem_be      <= 4'b0000;
         wb_rd        <= 5'd0;
         wb_data      <= 32'h0;
         wb_reg_write <= 1'b0;
         funct3_q     <= 3'b000;
         lane_q       <= 2'b00;
         load_q       <= 1'b0;
         fault_q      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  wb_rd    <= ex_rd;
                  funct3_q <= ex_funct3;
                  lane_q   <= lane_in;
                  load_q   <= ex_mem_read;
                  fault_q  <= fault;
                  if (fault) begin
                     wb_data      <= 32'h0;
                     wb_reg_write <= 1'b0;
                  end else if (!mem_op) begin
                     wb_data      <= ex_alu_out;
                     wb_reg_write <= ex_reg_write;
                  end else begin
                     dmem_req     <= 1'b1;
                     dmem_we      <= ex_mem_write;
                     dmem_addr    <= {ex_alu_out[31:2], 2'b00};
                     dmem_be      <= be_in;
                     dmem_wdata   <= wdata_in;
                     wb_data      <= 32'h0;
                     // Stores never write the register file
                     wb_reg_write <= ex_reg_write & ex_mem_read;
                  end
               end
            end
            WAIT: begin
               if (dmem_ack) begin
                  dmem_req <= 1'b0;
                  if (load_q)
                     wb_data <= load_data;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
`default_nettype wire
